// File: rtl/punc_control_fsm.sv
// Control-path FSM for the PUnC LC3 core: FETCH/DECODE/EXEC(/EXEC2)/HALT sequencing and datapath strobes.
// Optional retired-instruction counter (instr_count) enabled by defining PUNC_CTRL_PERF_EN.
module punc_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       bitfive,
  input  logic       biteleven,
  input  logic       br_enable,
  output logic       ir_ld,
  output logic       decode,
  output logic [1:0] extend,
  output logic [1:0] op1,
  output logic       op2,
  output logic [2:0] result,
  output logic       rf_w_en,
  output logic [1:0] pc_select,
  output logic       branch,
  output logic [2:0] mem_read_loc,
  output logic [1:0] mem_write_loc,
  output logic       mem_w_en,
  output logic       halted,
  output logic [2:0] state_dbg
`ifdef PUNC_CTRL_PERF_EN
  ,
  output logic [15:0] instr_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_EXEC2  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    ir_ld         = 1'b0;
    decode        = 1'b0;
    extend        = 2'd0;
    op1           = 2'd0;
    op2           = 1'b0;
    result        = 3'd0;
    rf_w_en       = 1'b0;
    pc_select     = 2'd0;
    branch        = 1'b0;
    mem_read_loc  = 3'd0;
    mem_write_loc = 2'd0;
    mem_w_en      = 1'b0;
    halted        = 1'b0;
    state_dbg     = 3'd0;
    // Reset gates every strobe so an abandoned instruction can never write.
    if (!rst) begin
      state_dbg = state_q;
      case (state_q)
        S_FETCH: begin
          ir_ld   = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          decode  = 1'b1;
          state_d = (opcode == OP_TRAP) ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          state_d = S_FETCH;
          case (opcode)
            OP_ADD, OP_AND: begin
              op1     = 2'd1;
              op2     = bitfive;
              result  = (opcode == OP_ADD) ? 3'd1 : 3'd2;
              rf_w_en = 1'b1;
            end
            OP_NOT: begin
              result  = 3'd3;
              rf_w_en = 1'b1;
            end
            OP_BR: begin
              extend = 2'd2;
              branch = br_enable;
            end
            OP_JMP: pc_select = 2'd1;
            OP_JSR: begin
              pc_select = biteleven ? 2'd2 : 2'd3;
              extend    = 2'd3;
              result    = 3'd5;
              rf_w_en   = 1'b1;
            end
            OP_LD: begin
              extend       = 2'd2;
              mem_read_loc = 3'd1;
              result       = 3'd4;
              rf_w_en      = 1'b1;
            end
            OP_LDR: begin
              op1          = 2'd3;
              extend       = 2'd1;
              mem_read_loc = 3'd2;
              result       = 3'd4;
              rf_w_en      = 1'b1;
            end
            OP_LEA: begin
              op1     = 2'd2;
              op2     = 1'b1;
              extend  = 2'd2;
              result  = 3'd1;
              rf_w_en = 1'b1;
            end
            OP_ST: begin
              extend        = 2'd2;
              mem_write_loc = 2'd1;
              mem_w_en      = 1'b1;
            end
            OP_STR: begin
              extend        = 2'd1;
              mem_write_loc = 2'd2;
              mem_w_en      = 1'b1;
            end
            OP_LDI: begin
              extend       = 2'd2;
              mem_read_loc = 3'd3;
              state_d      = S_EXEC2;
            end
            // First STI cycle only reads the pointer; the store happens in EXEC2.
            OP_STI: begin
              extend        = 2'd2;
              mem_write_loc = 2'd3;
              state_d       = S_EXEC2;
            end
            default: ;
          endcase
        end
        S_EXEC2: begin
          state_d = S_FETCH;
          if (opcode == OP_LDI) begin
            mem_read_loc = 3'd4;
            result       = 3'd4;
            rf_w_en      = 1'b1;
          end else if (opcode == OP_STI) begin
            extend        = 2'd2;
            mem_write_loc = 2'd3;
            mem_w_en      = 1'b1;
          end
        end
        S_HALT: halted = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
  end

`ifdef PUNC_CTRL_PERF_EN
  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (rst)
      count_q <= 16'd0;
    else if ((state_q == S_EXEC || state_q == S_EXEC2) && state_d == S_FETCH)
      count_q <= count_q + 16'd1;
  end

  assign instr_count = rst ? 16'd0 : count_q;
`endif

endmodule

// File: tb/tb_punc_control_fsm.sv
// Scoreboard bench for punc_control_fsm: per-cycle expected output vectors are queued as
// stimulus is driven and popped when the combinational outputs are sampled mid-cycle.
module tb_punc_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       bitfive, biteleven, br_enable;
  logic       ir_ld, decode, op2, rf_w_en, branch, mem_w_en, halted;
  logic [1:0] extend, op1, pc_select, mem_write_loc;
  logic [2:0] result, mem_read_loc, state_dbg;
`ifdef PUNC_CTRL_PERF_EN
  logic [15:0] instr_count;
`endif

  always #5 clk = ~clk;

  punc_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .bitfive(bitfive), .biteleven(biteleven),
    .br_enable(br_enable), .ir_ld(ir_ld), .decode(decode), .extend(extend), .op1(op1),
    .op2(op2), .result(result), .rf_w_en(rf_w_en), .pc_select(pc_select), .branch(branch),
    .mem_read_loc(mem_read_loc), .mem_write_loc(mem_write_loc), .mem_w_en(mem_w_en),
    .halted(halted), .state_dbg(state_dbg)
`ifdef PUNC_CTRL_PERF_EN
    , .instr_count(instr_count)
`endif
  );

  typedef struct packed {
    logic       ir_ld;
    logic       decode;
    logic [1:0] extend;
    logic [1:0] op1;
    logic       op2;
    logic [2:0] result;
    logic       rf_w_en;
    logic [1:0] pc_select;
    logic       branch;
    logic [2:0] mem_read_loc;
    logic [1:0] mem_write_loc;
    logic       mem_w_en;
    logic       halted;
    logic [2:0] state_dbg;
  } ovec_t;

  ovec_t got;
  ovec_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_ret = 0;

  assign got = {ir_ld, decode, extend, op1, op2, result, rf_w_en, pc_select, branch,
                mem_read_loc, mem_write_loc, mem_w_en, halted, state_dbg};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step(input string tag, input ovec_t e);
    ovec_t x;
    exp_q.push_back(e);
    #1;
    x = exp_q.pop_front();
    chk(tag, 32'(got), 32'(x));
    @(negedge clk);
  endtask

  function automatic ovec_t st(input logic [2:0] s);
    ovec_t e;
    e = '0;
    e.state_dbg = s;
    return e;
  endfunction

  task automatic instr(input string tag, input logic [3:0] op, input logic b5, input logic b11,
                       input logic bre, input ovec_t ex, input bit two, input ovec_t ex2);
    ovec_t f, d;
    opcode = op; bitfive = b5; biteleven = b11; br_enable = bre;
    f = st(3'd0); f.ir_ld = 1'b1;
    d = st(3'd1); d.decode = 1'b1;
    step({tag, "/fetch"}, f);
    step({tag, "/decode"}, d);
    step({tag, "/exec"}, ex);
    if (two) step({tag, "/exec2"}, ex2);
    n_ret++;
  endtask

  initial begin
    ovec_t e, e2, z, f, d;
    z = '0;
    f = st(3'd0); f.ir_ld = 1'b1;
    d = st(3'd1); d.decode = 1'b1;
    rst = 1'b1; opcode = 4'b0001; bitfive = 1'b1; biteleven = 1'b0; br_enable = 1'b0;
    @(negedge clk);
    step("rst_c0", z);
    step("rst_c1", z);
    rst = 1'b0;
`ifdef PUNC_CTRL_PERF_EN
    #1 chk("cnt_after_rst", 32'(instr_count), 32'd0);
`endif

    // Five ADDs, alternating immediate and register forms.
    for (int i = 0; i < 5; i++) begin
      e = st(3'd2); e.op1 = 2'd1; e.op2 = i[0] ? 1'b0 : 1'b1; e.result = 3'd1; e.rf_w_en = 1'b1;
      instr("add", 4'b0001, ~i[0], 1'b0, 1'b0, e, 1'b0, z);
    end
`ifdef PUNC_CTRL_PERF_EN
    #1 chk("cnt_5_adds", 32'(instr_count), 32'd5);
`endif

    e = st(3'd2); e.op1 = 2'd1; e.result = 3'd2; e.rf_w_en = 1'b1;
    instr("and_reg", 4'b0101, 1'b0, 1'b0, 1'b0, e, 1'b0, z);
    e = st(3'd2); e.result = 3'd3; e.rf_w_en = 1'b1;
    instr("not", 4'b1001, 1'b1, 1'b1, 1'b1, e, 1'b0, z);
    e = st(3'd2); e.extend = 2'd2;
    instr("br_nt", 4'b0000, 1'b0, 1'b0, 1'b0, e, 1'b0, z);
    e.branch = 1'b1;
    instr("br_t", 4'b0000, 1'b0, 1'b0, 1'b1, e, 1'b0, z);
    e = st(3'd2); e.pc_select = 2'd1;
    instr("jmp", 4'b1100, 1'b0, 1'b0, 1'b0, e, 1'b0, z);
    e = st(3'd2); e.pc_select = 2'd2; e.extend = 2'd3; e.result = 3'd5; e.rf_w_en = 1'b1;
    instr("jsr", 4'b0100, 1'b0, 1'b1, 1'b0, e, 1'b0, z);
    e.pc_select = 2'd3;
    instr("jsrr", 4'b0100, 1'b0, 1'b0, 1'b0, e, 1'b0, z);
    e = st(3'd2); e.extend = 2'd2; e.mem_read_loc = 3'd1; e.result = 3'd4; e.rf_w_en = 1'b1;
    instr("ld", 4'b0010, 1'b0, 1'b0, 1'b0, e, 1'b0, z);
    e = st(3'd2); e.op1 = 2'd3; e.extend = 2'd1; e.mem_read_loc = 3'd2; e.result = 3'd4; e.rf_w_en = 1'b1;
    instr("ldr", 4'b0110, 1'b0, 1'b0, 1'b0, e, 1'b0, z);
    e = st(3'd2); e.op1 = 2'd2; e.op2 = 1'b1; e.extend = 2'd2; e.result = 3'd1; e.rf_w_en = 1'b1;
    instr("lea", 4'b1110, 1'b0, 1'b0, 1'b0, e, 1'b0, z);
    e = st(3'd2); e.extend = 2'd2; e.mem_write_loc = 2'd1; e.mem_w_en = 1'b1;
    instr("st", 4'b0011, 1'b0, 1'b0, 1'b0, e, 1'b0, z);
    e = st(3'd2); e.extend = 2'd1; e.mem_write_loc = 2'd2; e.mem_w_en = 1'b1;
    instr("str", 4'b0111, 1'b0, 1'b0, 1'b0, e, 1'b0, z);
    e = st(3'd2); e.extend = 2'd2; e.mem_read_loc = 3'd3;
    e2 = st(3'd3); e2.mem_read_loc = 3'd4; e2.result = 3'd4; e2.rf_w_en = 1'b1;
    instr("ldi", 4'b1010, 1'b0, 1'b0, 1'b0, e, 1'b1, e2);
    e = st(3'd2); e.extend = 2'd2; e.mem_write_loc = 2'd3;
    e2 = st(3'd3); e2.extend = 2'd2; e2.mem_write_loc = 2'd3; e2.mem_w_en = 1'b1;
    instr("sti", 4'b1011, 1'b0, 1'b0, 1'b0, e, 1'b1, e2);
    instr("rti", 4'b1000, 1'b1, 1'b1, 1'b1, st(3'd2), 1'b0, z);
    instr("rsvd", 4'b1101, 1'b1, 1'b1, 1'b1, st(3'd2), 1'b0, z);

    // TRAP: halt and stay there with no strobes until reset.
    opcode = 4'b1111; bitfive = 1'b1; biteleven = 1'b1; br_enable = 1'b1;
    step("trap/fetch", f);
    step("trap/decode", d);
    e = st(3'd4); e.halted = 1'b1;
    for (int i = 0; i < 20; i++) step("halt", e);
`ifdef PUNC_CTRL_PERF_EN
    #1 chk("cnt_frozen_halt", 32'(instr_count), 32'(n_ret));
`endif
    rst = 1'b1;
    step("halt_rst", z);
    rst = 1'b0;
    n_ret = 0;
`ifdef PUNC_CTRL_PERF_EN
    #1 chk("cnt_after_halt_rst", 32'(instr_count), 32'd0);
`endif

    // Reset during the store cycle of STI must suppress the write.
    opcode = 4'b1011; bitfive = 1'b0; biteleven = 1'b0; br_enable = 1'b0;
    step("sti_abort/fetch", f);
    step("sti_abort/decode", d);
    e = st(3'd2); e.extend = 2'd2; e.mem_write_loc = 2'd3;
    step("sti_abort/exec", e);
    rst = 1'b1;
    step("sti_abort/rst_exec2", z);
    rst = 1'b0;
    e = st(3'd2); e.op1 = 2'd1; e.op2 = 1'b1; e.result = 3'd1; e.rf_w_en = 1'b1;
    instr("add_after_abort", 4'b0001, 1'b1, 1'b0, 1'b0, e, 1'b0, z);
`ifdef PUNC_CTRL_PERF_EN
    #1 chk("cnt_after_abort", 32'(instr_count), 32'(n_ret));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
